// File: rtl/render_queue.sv
// render_queue: Avalon-MM programmed FIFO of 48-bit render instructions.
//
// A host stages an instruction in two writes and the consumer takes
// entries from a show-ahead head register (zero pop latency).
//
// Ports:
//   clk50                  - sole clock, rising edge
//   reset_n                - asynchronous active-low reset
//   chipselect             - Avalon-MM slave select
//   write, read            - Avalon strobes
//   address[1:0]           - 0: stage {x,y}   1: {magic,flags} + commit
//                            2: status read   3: control (bit0 flush,
//                            bit1 clear overflow/proto_err)
//   writedata[31:0]        - Avalon write data
//   readdata[31:0]         - registered status, one cycle after the read,
//                            zero otherwise
//   render_queue_pop_front - consumer pop request
//   render_queue_dout[47:0]- head {magic, x, y, flags}, or
//                            {`VGA_DO_RENDER, 40'h0} when nothing is presentable
//
// Build option: define RENDER_QUEUE_FRAME_GATE_EN to present entries only
// once a whole frame (terminated by a `VGA_DO_RENDER entry) is queued.

`ifndef VGA_DO_RENDER
`define VGA_DO_RENDER 8'h01
`endif

module render_queue #(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [1:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        render_queue_pop_front,
    output logic [47:0] render_queue_dout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [0:0] STAGE_EMPTY = 1'b0;
    localparam logic [0:0] STAGE_HALF  = 1'b1;

    localparam logic [7:0]  DO_RENDER = `VGA_DO_RENDER;
    localparam logic [47:0] IDLE_WORD = {DO_RENDER, 40'h0};

    logic [47:0]   mem [DEPTH];

    logic [AW-1:0] wptr_q,  wptr_d;
    logic [AW-1:0] rptr_q,  rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    stage_q, stage_d;
    logic [31:0]   xy_q,    xy_d;
    logic          ovf_q,   ovf_d;
    logic          perr_q,  perr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [47:0]   dout_q,  dout_d;

    logic        stage_wr, commit_wr, ctrl_wr, stat_rd;
    logic        flush, clr_err;
    logic        full, empty, presentable, next_presentable;
    logic        push_req, push_acc, pop_acc;
    logic [47:0] new_entry;

`ifdef RENDER_QUEUE_FRAME_GATE_EN
    logic [CW-1:0] fp_q, fp_d;
`endif

    assign stage_wr  = chipselect && write && (address == 2'd0);
    assign commit_wr = chipselect && write && (address == 2'd1);
    assign ctrl_wr   = chipselect && write && (address == 2'd3);
    assign stat_rd   = chipselect && read  && (address == 2'd2);

    assign flush   = ctrl_wr && writedata[0];
    assign clr_err = ctrl_wr && writedata[1];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

`ifdef RENDER_QUEUE_FRAME_GATE_EN
    assign presentable = !empty && (fp_q != '0);
`else
    assign presentable = !empty;
`endif

    assign new_entry = {writedata[15:8], xy_q, writedata[7:0]};
    assign pop_acc   = render_queue_pop_front && presentable && !flush;
    assign push_req  = commit_wr && (stage_q == STAGE_HALF);
    // A full queue still takes the push when the head leaves this cycle.
    assign push_acc  = push_req && !flush && (!full || pop_acc);

    always_comb begin
        stage_d = stage_q;
        xy_d    = xy_q;
        ovf_d   = ovf_q;
        perr_d  = perr_q;
        wptr_d  = wptr_q + AW'(push_acc);
        rptr_d  = rptr_q + AW'(pop_acc);
        count_d = count_q;

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (stage_wr) begin
            stage_d = STAGE_HALF;
            xy_d    = writedata;
        end else if (commit_wr) begin
            stage_d = STAGE_EMPTY;
        end

        if (clr_err) begin
            ovf_d  = 1'b0;
            perr_d = 1'b0;
        end else begin
            if (push_req && !flush && !push_acc) ovf_d = 1'b1;
            if (commit_wr && (stage_q == STAGE_EMPTY)) perr_d = 1'b1;
        end

        if (flush) begin
            stage_d = STAGE_EMPTY;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

`ifdef RENDER_QUEUE_FRAME_GATE_EN
    always_comb begin
        fp_d = fp_q;
        case ({push_acc && (writedata[15:8] == DO_RENDER),
               pop_acc  && (dout_q[47:40]   == DO_RENDER)})
            2'b10:   fp_d = fp_q + CW'(1);
            2'b01:   fp_d = fp_q - CW'(1);
            default: fp_d = fp_q;
        endcase
        if (flush) fp_d = '0;
    end

    assign next_presentable = (count_d != '0) && (fp_d != '0);
`else
    assign next_presentable = (count_d != '0);
`endif

    // Head register looks one edge ahead. The only way the next head can be
    // the entry being written this cycle is a push whose slot equals the
    // next read pointer, so that case bypasses the RAM.
    always_comb begin
        if (!next_presentable) begin
            dout_d = IDLE_WORD;
        end else if (push_acc && (wptr_q == rptr_d)) begin
            dout_d = new_entry;
        end else begin
            dout_d = mem[rptr_d];
        end
    end

    always_comb begin
        rdata_d = '0;
        if (stat_rd) begin
            rdata_d = {full, empty, ovf_q, perr_q, 12'b0, 16'(count_q)};
        end
    end

    always_ff @(posedge clk50) begin
        if (push_acc) mem[wptr_q] <= new_entry;
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            stage_q <= STAGE_EMPTY;
            xy_q    <= '0;
            ovf_q   <= 1'b0;
            perr_q  <= 1'b0;
            rdata_q <= '0;
            dout_q  <= IDLE_WORD;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            stage_q <= stage_d;
            xy_q    <= xy_d;
            ovf_q   <= ovf_d;
            perr_q  <= perr_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
        end
    end

`ifdef RENDER_QUEUE_FRAME_GATE_EN
    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) fp_q <= '0;
        else          fp_q <= fp_d;
    end
`endif

    assign readdata          = rdata_q;
    assign render_queue_dout = dout_q;

endmodule
